// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the instruction memory and
// loads the IF/ID pipeline register with redirect, stall and halt handling.

package instruction_fetch_unit_pkg;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

endpackage

module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 65,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc4_o,
    output logic        if_id_valid_o,
    output logic        halted_o,
    output logic        misalign_o,
    output logic [31:0] fetch_count_o
);

    localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4;
    if_id_t      if_id_q;
    if_id_t      if_id_d;
    if_id_t      bubble;
    logic        misalign_q;
    logic        misalign_d;
    logic [31:0] count_q;
    logic [31:0] count_d;
    logic        halted;
    logic        do_redirect;
    logic        do_halt;
    logic        do_stall;
    logic        do_fetch;

    assign pc_plus4 = pc_q + 32'd4;
    assign halted   = (pc_q >= PC_LIMIT);

    assign bubble.instr = NOP_WORD;
    assign bubble.pc    = 32'h0;
    assign bubble.pc4   = 32'h0;
    assign bubble.valid = 1'b0;

    // Mutually exclusive decode of the per-edge priority order.
    assign do_redirect = redirect_i;
    assign do_halt     = !redirect_i && halted;
    assign do_stall    = !redirect_i && !halted && stall_i;
    assign do_fetch    = !redirect_i && !halted && !stall_i;

    always_comb begin
        pc_d       = pc_q;
        if_id_d    = if_id_q;
        misalign_d = misalign_q;
        count_d    = count_q;
        unique case (1'b1)
            do_redirect: begin
                pc_d       = {redirect_pc_i[31:2], 2'b00};
                if_id_d    = bubble;
                misalign_d = misalign_q | (|redirect_pc_i[1:0]);
            end
            do_halt: begin
                if (!stall_i) begin
                    if_id_d = bubble;
                end
            end
            do_stall: begin
            end
            do_fetch: begin
                if_id_d.instr = imem_instr_i;
                if_id_d.pc    = pc_q;
                if_id_d.pc4   = pc_plus4;
                if_id_d.valid = 1'b1;
                pc_d          = pc_plus4;
                count_d       = count_q + 32'd1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            pc_q       <= RESET_PC;
            if_id_q    <= bubble;
            misalign_q <= 1'b0;
            count_q    <= 32'h0;
        end else begin
            pc_q       <= pc_d;
            if_id_q    <= if_id_d;
            misalign_q <= misalign_d;
            count_q    <= count_d;
        end
    end

    assign imem_addr_o   = pc_q;
    assign if_id_instr_o = if_id_q.instr;
    assign if_id_pc_o    = if_id_q.pc;
    assign if_id_pc4_o   = if_id_q.pc4;
    assign if_id_valid_o = if_id_q.valid;
    assign halted_o      = halted;
    assign misalign_o    = misalign_q;
    assign fetch_count_o = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus
// random stall/redirect traffic against a behavioural fetch model.

module tb_instruction_fetch_unit;

    localparam int WORDS = 65;
    localparam logic [31:0] LIMIT = 32'd260;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic [31:0] o_pc4;
    logic        o_valid;
    logic        o_halted;
    logic        o_mis;
    logic [31:0] o_cnt;

    logic [31:0] mem [WORDS];

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        m_mis;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    assign imem_instr = (imem_addr < LIMIT) ? mem[imem_addr[8:2]]
                                            : 32'hBAD0_BAD0;

    instruction_fetch_unit #(
        .RESET_PC  (32'h0),
        .IMEM_WORDS(WORDS),
        .NOP_WORD  (32'h0)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .imem_addr_o  (imem_addr),
        .imem_instr_i (imem_instr),
        .stall_i      (stall),
        .redirect_i   (redir),
        .redirect_pc_i(rpc),
        .if_id_instr_o(o_instr),
        .if_id_pc_o   (o_pc),
        .if_id_pc4_o  (o_pc4),
        .if_id_valid_o(o_valid),
        .halted_o     (o_halted),
        .misalign_o   (o_mis),
        .fetch_count_o(o_cnt)
    );

    wire [162:0] obs = {o_instr, o_pc, o_pc4, o_valid, o_halted,
                        o_mis, o_cnt, imem_addr};

    function automatic logic [162:0] expv();
        return {m_instr, m_ipc, m_pc4, m_valid, (m_pc >= LIMIT),
                m_mis, m_cnt, m_pc};
    endfunction

    task automatic bubble_model();
        m_instr = 32'h0;
        m_ipc   = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
    endtask

    // Apply inputs, advance one edge, update the model, settle past the edge.
    task automatic step(input logic r, input logic s, input logic d,
                        input logic [31:0] t);
        rst   = r;
        stall = s;
        redir = d;
        rpc   = t;
        @(posedge clk);
        if (!r) begin
            m_pc = 32'h0;
            bubble_model();
            m_mis = 1'b0;
            m_cnt = 32'h0;
        end else if (d) begin
            m_pc = t & 32'hFFFF_FFFC;
            bubble_model();
            if (t[1:0] != 2'b00) m_mis = 1'b1;
        end else if (m_pc >= LIMIT) begin
            if (!s) bubble_model();
        end else if (!s) begin
            m_instr = mem[m_pc / 4];
            m_ipc   = m_pc;
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            m_cnt   = m_cnt + 32'd1;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (obs !== {32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
                     32'h0, 32'h0})
            $display("FAIL reset_state got %h want all-zero", obs);
        else n_pass++;
    endtask

    task automatic test_free_run();
        logic [31:0] want [4];
        want[0] = 32'h11; want[1] = 32'h22;
        want[2] = 32'h33; want[3] = 32'h44;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            n_checks++;
            if (o_instr !== want[k] || o_pc !== 32'(k * 4) ||
                o_pc4 !== 32'(k * 4 + 4) || o_valid !== 1'b1)
                $display("FAIL free_run[%0d] got %h/%h/%h/%b want %h/%h/%h/1",
                         k, o_instr, o_pc, o_pc4, o_valid,
                         want[k], k * 4, k * 4 + 4);
            else n_pass++;
        end
        n_checks++;
        if (o_cnt !== 32'd4 || obs !== expv())
            $display("FAIL free_run_count got %0d want 4", o_cnt);
        else n_pass++;
    endtask

    task automatic test_stall();
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            n_checks++;
            if (imem_addr !== 32'd8 || o_instr !== mem[1] ||
                o_pc !== 32'd4 || o_cnt !== 32'd2)
                $display("FAIL stall_hold[%0d] got addr=%h instr=%h pc=%h cnt=%0d want 8/%h/4/2",
                         k, imem_addr, o_instr, o_pc, o_cnt, mem[1]);
            else n_pass++;
        end
        step(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (o_instr !== mem[2] || o_pc !== 32'd8 || o_cnt !== 32'd3)
            $display("FAIL stall_release got instr=%h pc=%h cnt=%0d want %h/8/3",
                     o_instr, o_pc, o_cnt, mem[2]);
        else n_pass++;
    endtask

    task automatic test_redirect_stall();
        step(1'b1, 1'b1, 1'b1, 32'h20);
        n_checks++;
        if (o_valid !== 1'b0 || imem_addr !== 32'h20 || obs !== expv())
            $display("FAIL redirect_stall got valid=%b addr=%h want 0/20",
                     o_valid, imem_addr);
        else n_pass++;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (o_pc !== 32'h20 || o_instr !== mem[8] || o_valid !== 1'b1)
            $display("FAIL redirect_target got pc=%h instr=%h want 20/%h",
                     o_pc, o_instr, mem[8]);
        else n_pass++;
    endtask

    task automatic test_misalign();
        step(1'b1, 1'b0, 1'b1, 32'h16);
        n_checks++;
        if (imem_addr !== 32'h14 || o_mis !== 1'b1)
            $display("FAIL misalign_set got addr=%h mis=%b want 14/1",
                     imem_addr, o_mis);
        else n_pass++;
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'($urandom_range(0, 3) == 0), 1'b0, 32'h0);
            n_checks++;
            if (o_mis !== 1'b1 || obs !== expv())
                $display("FAIL misalign_sticky[%0d] got %h want %h",
                         k, obs, expv());
            else n_pass++;
        end
        step(1'b1, 1'b0, 1'b1, 32'h40);
        n_checks++;
        if (o_mis !== 1'b1 || imem_addr !== 32'h40)
            $display("FAIL misalign_after_redirect got mis=%b addr=%h want 1/40",
                     o_mis, imem_addr);
        else n_pass++;
    endtask

    task automatic test_end_of_mem();
        step(1'b0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < WORDS; k++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            n_checks++;
            if (obs !== expv())
                $display("FAIL end_run[%0d] got %h want %h", k, obs, expv());
            else n_pass++;
        end
        n_checks++;
        if (o_pc !== 32'h100 || o_valid !== 1'b1 || o_halted !== 1'b1 ||
            imem_addr !== 32'h104 || o_cnt !== 32'd65)
            $display("FAIL last_fetch got pc=%h v=%b h=%b addr=%h cnt=%0d want 100/1/1/104/65",
                     o_pc, o_valid, o_halted, imem_addr, o_cnt);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'(k == 2), 1'b0, 32'h0);
            n_checks++;
            if (o_valid !== 1'b0 || o_halted !== 1'b1 ||
                imem_addr !== 32'h104 || o_cnt !== 32'd65)
                $display("FAIL halted[%0d] got v=%b h=%b addr=%h cnt=%0d want 0/1/104/65",
                         k, o_valid, o_halted, imem_addr, o_cnt);
            else n_pass++;
        end
        step(1'b1, 1'b0, 1'b1, 32'h0);
        n_checks++;
        if (o_halted !== 1'b0 || imem_addr !== 32'h0)
            $display("FAIL unhalt got h=%b addr=%h want 0/0", o_halted, imem_addr);
        else n_pass++;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (o_instr !== mem[0] || o_pc !== 32'h0 || o_valid !== 1'b1)
            $display("FAIL restart got instr=%h pc=%h v=%b want %h/0/1",
                     o_instr, o_pc, o_valid, mem[0]);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] t;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 3))
                0: t = $urandom_range(0, 64) * 4;
                1: t = $urandom_range(0, 259);
                2: t = $urandom_range(260, 400);
                default: t = 32'hFFFF_FFFC;
            endcase
            step(1'b1, 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 9) == 0), t);
            n_checks++;
            if (obs !== expv())
                $display("FAIL random[%0d] got %h want %h", k, obs, expv());
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b0, 1'b1, 32'h2);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h33);
        n_checks++;
        if (obs !== {32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
                     32'h0, 32'h0})
            $display("FAIL reset_mid got %h want all-zero", obs);
        else n_pass++;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (o_pc !== 32'h0 || o_instr !== mem[0] || o_cnt !== 32'd1 ||
            o_mis !== 1'b0)
            $display("FAIL reset_mid_fetch got pc=%h instr=%h cnt=%0d mis=%b want 0/%h/1/0",
                     o_pc, o_instr, o_cnt, o_mis, mem[0]);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        mem[0] = 32'h11; mem[1] = 32'h22;
        mem[2] = 32'h33; mem[3] = 32'h44;
        rst = 1'b0; stall = 1'b0; redir = 1'b0; rpc = 32'h0;
        m_pc = 32'h0; m_mis = 1'b0; m_cnt = 32'h0;
        bubble_model();
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_stall();
        test_misalign();
        test_end_of_mem();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface.
- Owns the program counter, drives the word-fetch byte address to the instruction memory, and captures the returned word.
- Registers the fetched instruction, its PC and its PC+4 into the IF/ID pipeline register for decode.
- Handles stall, branch/jump redirect, misaligned targets and fetches past the end of the memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 65, instruction memory depth in 32-bit words; byte addresses >= IMEM_WORDS*4 are out of range.
- NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID for bubbles.

Ports:
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  synchronous reset, active-low.
- imem_addr_o  output  32  byte address to instruction memory; equals the current PC, combinational from the PC register.
- imem_instr_i  input  32  instruction word returned combinationally for imem_addr_o.
- stall_i  input  1  hazard stall: hold the PC and IF/ID.
- redirect_i  input  1  taken branch or jump resolved in a later stage.
- redirect_pc_i  input  32  target byte address for the redirect.
- if_id_instr_o  output  32  registered instruction.
- if_id_pc_o  output  32  registered PC of if_id_instr_o.
- if_id_pc4_o  output  32  registered PC+4.
- if_id_valid_o  output  1  1 = IF/ID holds a real instruction.
- halted_o  output  1  1 = PC is out of range; fetch suspended.
- misalign_o  output  1  sticky flag; a redirect target had bits [1:0] != 0.
- fetch_count_o  output  32  number of valid instructions delivered into IF/ID.

Behaviour:
- Reset (rst_i == 0 at a rising edge), all registers:
  - PC = RESET_PC
  - if_id_instr_o = NOP_WORD
  - if_id_pc_o = 0, if_id_pc4_o = 0
  - if_id_valid_o = 0
  - halted_o = 0, misalign_o = 0
  - fetch_count_o = 0
- Reset overrides every other input on the same edge.
- Reset asserted mid-operation discards the pending IF/ID contents and any redirect.
- Latency: the instruction at PC appears on if_id_* on the edge after PC is presented. One instruction per cycle in steady state.
- Priority per edge (highest first): reset > redirect_i > halted > stall_i > normal fetch.
- Normal (not halted, no stall, no redirect):
  - IF/ID <= {imem_instr_i, PC, PC+4}, valid = 1.
  - PC <= PC+4; fetch_count_o increments.
- Stall (stall_i = 1, no redirect):
  - PC and all IF/ID outputs hold; fetch_count_o holds.
  - imem_addr_o stays stable.
- Redirect (redirect_i = 1, regardless of stall_i or halted):
  - PC <= {redirect_pc_i[31:2], 2'b00}.
  - IF/ID becomes a bubble: NOP_WORD, valid = 0, pc and pc4 = 0. This flushes the wrong-path instruction.
  - halted_o is re-evaluated from the new PC on the next cycle.
  - If redirect_pc_i[1:0] != 0, misalign_o <= 1. It stays set until reset.
- Out of range (PC >= IMEM_WORDS*4, i.e. word index > IMEM_WORDS-1):
  - halted_o = 1 (combinational on PC, also visible the same cycle).
  - The PC does not advance.
  - IF/ID loads a bubble each non-stalled cycle; imem_instr_i is ignored.
  - Fetch resumes only via a redirect to an in-range address.
- PC arithmetic is modulo 2^32; PC+4 wraps silently, and a wrapped PC is then evaluated by the range check.
- fetch_count_o wraps at 2^32.
- Multiple events in one cycle resolve strictly by the priority above: stall + redirect => redirect wins.

Test Plan:
- Reset then free run, memory words 0..3 = 0x11, 0x22, 0x33, 0x44:
  - cycle 0: if_id_valid_o = 0.
  - cycles 1–4: if_id_instr_o = 0x11, 0x22, 0x33, 0x44; if_id_pc_o = 0, 4, 8, 12; if_id_pc4_o = 4, 8, 12, 16.
  - fetch_count_o = 4.
- stall_i held 3 cycles at PC = 8:
  - imem_addr_o stays 8; if_id_instr_o stays word 1 with pc = 4.
  - On release, word 2 arrives with pc = 8; count unchanged during the stall.
- redirect_i with redirect_pc_i = 0x20 while stall_i = 1:
  - Next edge: if_id_valid_o = 0, imem_addr_o = 0x20.
  - Following edge: if_id_pc_o = 0x20, instruction = word 8.
- Redirect to 0x0000_0016:
  - PC becomes 0x14; misalign_o = 1 and remains 1 across 10 further cycles and later redirects.
- Free run to the end of memory (IMEM_WORDS = 65):
  - Last valid fetch has pc = 0x100.
  - PC then holds at 0x104; halted_o = 1; if_id_valid_o = 0 every cycle; count stays 65.
  - Redirect to 0 clears halted_o and fetch restarts at word 0.
- Reset asserted mid-run with redirect_i = 1 on the same edge:
  - PC = RESET_PC, all outputs at reset values.
  - misalign_o = 0 even with a misaligned redirect_pc_i.
